// File: rtl/fir_bank_pkg.sv
// Shared types and the accumulator-to-output scaling function for the serial FIR bank.
// Define FIR_BANK_ROUND_EN to round half up before the shift; otherwise the shift truncates (floor).
package fir_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } state_t;

  // Widest accumulator the scaling function can take; lanes sign-extend into it.
  localparam int MAX_W = 128;

  function automatic logic signed [MAX_W-1:0] sat_shift(
    input logic signed [MAX_W-1:0] acc,
    input int                      shift,
    input int                      out_w
  );
    logic signed [MAX_W-1:0] v;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    v = acc;
`ifdef FIR_BANK_ROUND_EN
    v = v + (MAX_W'(1) <<< (shift - 1));
`endif
    v  = v >>> shift;
    hi = (MAX_W'(1) <<< (out_w - 1)) - MAX_W'(1);
    lo = -hi - MAX_W'(1);
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One channel of the FIR bank: coefficient store, multiply-accumulate and a saturating output register.
module fir_mac_lane
  import fir_bank_pkg::*;
#(
  parameter int N_TAPS    = 120,
  parameter int IN_W      = 12,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 31,
  parameter int OUT_SHIFT = 8,
  localparam int PW       = $clog2(N_TAPS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     coef_we,
  input  logic [PW-1:0]            coef_idx,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic [PW-1:0]            tap,
  input  logic signed [IN_W-1:0]   x,
  input  logic                     clear,
  input  logic                     mac_en,
  input  logic                     load,
  output logic signed [OUT_W-1:0]  out_data
);

  logic signed [COEF_W-1:0]      coef [N_TAPS];
  logic signed [ACC_W-1:0]       acc;
  logic signed [IN_W+COEF_W-1:0] prod;

  // Both operands signed, result sized to the full product width: no precision lost.
  assign prod = x * coef[tap];

  // NOTE: the coefficient store is reset to zero on purpose so an unloaded
  // channel reads zero; this costs flops instead of a RAM macro.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        coef[i] <= '0;
      end
    end else if (coef_we) begin
      coef[coef_idx] <= coef_data;
    end
  end

  // NOTE: state updates use non-blocking assignments so every lane samples
  // the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      out_data <= '0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (mac_en) begin
        acc <= acc + ACC_W'(prod);
      end
      if (load) begin
        out_data <= OUT_W'(sat_shift(MAX_W'(acc), OUT_SHIFT, OUT_W));
      end
    end
  end

endmodule

// File: rtl/fir_bank_serial.sv
// Multi-channel serial FIR bank: shared circular delay line, one tap per cycle across all channels.
// Define FIR_BANK_ROUND_EN to round the scaled outputs half up instead of truncating.
module fir_bank_serial
  import fir_bank_pkg::*;
#(
  parameter int N_CH      = 16,
  parameter int N_TAPS    = 120,
  parameter int IN_W      = 12,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 31,
  parameter int OUT_SHIFT = 8,
  localparam int PW       = $clog2(N_TAPS),
  localparam int CW       = $clog2(N_CH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   coef_we,
  input  logic [CW-1:0]          coef_ch,
  input  logic [PW-1:0]          coef_idx,
  input  logic [COEF_W-1:0]      coef_data,
  output logic                   out_valid,
  output logic [N_CH*OUT_W-1:0]  out_data,
  output logic                   busy
);

  state_t                 state;
  logic [PW-1:0]          tap;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_idx;
  logic signed [IN_W-1:0] delay_line [N_TAPS];
  logic signed [IN_W-1:0] x;
  logic                   accept;
  logic                   coef_wr;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign coef_wr  = coef_we && (state == ST_IDLE)
                    && (int'(coef_ch) < N_CH) && (int'(coef_idx) < N_TAPS);

  // Tap k reads (wr_ptr - k) mod N_TAPS. Adding N_TAPS on underflow is correct
  // modulo 2^PW, so this also holds when N_TAPS is not a power of two.
  // NOTE: rd_idx gets a value on every path through the block, so no latch is inferred.
  always_comb begin
    rd_idx = wr_ptr - tap;
    if (wr_ptr < tap) begin
      rd_idx = wr_ptr - tap + PW'(N_TAPS);
    end
  end

  assign x = delay_line[rd_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      tap       <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        delay_line[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            delay_line[wr_ptr] <= in_data;
            tap                <= '0;
            state              <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (tap == PW'(N_TAPS - 1)) begin
            state <= ST_DONE;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        ST_DONE: begin
          out_valid <= 1'b1;
          wr_ptr    <= (wr_ptr == PW'(N_TAPS - 1)) ? '0 : wr_ptr + 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    fir_mac_lane #(
      .N_TAPS    (N_TAPS),
      .IN_W      (IN_W),
      .COEF_W    (COEF_W),
      .ACC_W     (ACC_W),
      .OUT_W     (OUT_W),
      .OUT_SHIFT (OUT_SHIFT)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .coef_we   (coef_wr && (int'(coef_ch) == c)),
      .coef_idx  (coef_idx),
      .coef_data (coef_data),
      .tap       (tap),
      .x         (x),
      .clear     (accept),
      .mac_en    (state == ST_MAC),
      .load      (state == ST_DONE),
      .out_data  (out_data[c*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_fir_bank_serial.sv
// Scoreboard bench for fir_bank_serial: directed samples, expected outputs queued at accept time.
module tb_fir_bank_serial;

  localparam int N_CH      = 2;
  localparam int N_TAPS    = 4;
  localparam int IN_W      = 12;
  localparam int COEF_W    = 16;
  localparam int ACC_W     = 40;
  localparam int OUT_W     = 8;
  localparam int OUT_SHIFT = 1;
`ifdef FIR_BANK_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data = '0;
  logic                  coef_we = 1'b0;
  logic [0:0]            coef_ch = '0;
  logic [1:0]            coef_idx = '0;
  logic [COEF_W-1:0]     coef_data = '0;
  logic                  out_valid;
  logic [N_CH*OUT_W-1:0] out_data;
  logic                  busy;

  fir_bank_serial #(
    .N_CH(N_CH), .N_TAPS(N_TAPS), .IN_W(IN_W), .COEF_W(COEF_W),
    .ACC_W(ACC_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .coef_we(coef_we), .coef_ch(coef_ch), .coef_idx(coef_idx),
    .coef_data(coef_data), .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { int x; int e0; int e1; } vec_t;
  typedef struct { int e0; int e1; int cyc; } exp_t;
  vec_t stim[$];
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lane(input int c);
    return int'($signed(out_data[c*OUT_W +: OUT_W]));
  endfunction

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ch0 out", lane(0), e.e0);
        check("ch1 out", lane(1), e.e1);
        check("latency", cyc - e.cyc, N_TAPS + 1);
      end
    end
  end

  task automatic write_coef(input int ch, input int idx, input int val);
    coef_we   = 1'b1;
    coef_ch   = 1'(ch);
    coef_idx  = 2'(idx);
    coef_data = COEF_W'(val);
    @(negedge clock);
    coef_we   = 1'b0;
  endtask

  task automatic write_row(input int ch, input int c0, input int c1, input int c2, input int c3);
    write_coef(ch, 0, c0);
    write_coef(ch, 1, c1);
    write_coef(ch, 2, c2);
    write_coef(ch, 3, c3);
  endtask

  task automatic push(input int x, input int e0, input int e1);
    stim.push_back('{x, e0, e1});
  endtask

  // Drives all queued samples with in_valid held high; checks accept spacing.
  task automatic stream();
    vec_t v;
    int   last_acc;
    int   w;
    last_acc = -1;
    while (stim.size() > 0) begin
      v        = stim.pop_front();
      in_valid = 1'b1;
      in_data  = IN_W'(v.x);
      w        = 0;
      while (!in_ready && w < 50) begin
        @(negedge clock);
        w++;
      end
      if (!in_ready) begin
        check("in_ready timeout", 0, 1);
        in_valid = 1'b0;
        stim.delete();
        return;
      end
      sb.push_back('{v.e0, v.e1, cyc + 1});
      if (last_acc >= 0) check("accept spacing", cyc + 1 - last_acc, N_TAPS + 2);
      last_acc = cyc + 1;
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      check("idle timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset in_ready", int'(in_ready), 1);
    check("reset busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // 1: impulse through ch0 {2,4,6,8}; ch1 unloaded
    write_row(0, 2, 4, 6, 8);
    push(1, 1, 0); push(0, 2, 0); push(0, 3, 0); push(0, 4, 0); push(0, 0, 0);
    stream();
    wait_idle();

    // 2: continuous in_valid, ch1 as a 4-tap moving sum
    write_row(1, 1, 1, 1, 1);
    push(2, 2, 1); push(4, 8, 3); push(6, 20, 6); push(8, 40, 10); push(10, 60, 14);
    stream();
    wait_idle();

    // 3: saturation at both rails
    write_row(0, 32767, 32767, 32767, 32767);
    write_row(1, -32768, -32768, -32768, -32768);
    push(2047, 127, -128); push(2047, 127, -128); push(2047, 127, -128); push(2047, 127, -128);
    stream();
    wait_idle();
    write_row(0, -32768, -32768, -32768, -32768);
    push(2047, -128, -128);
    stream();
    wait_idle();

    // 4: rounding vs truncation of acc = +/-3
    write_row(0, 3, 0, 0, 0);
    write_row(1, 0, 0, 0, 0);
    push(1, RND ? 2 : 1, 0);
    push(-1, RND ? -1 : -2, 0);
    stream();
    wait_idle();

    // 5: coefficient write during MAC is dropped
    in_valid = 1'b1;
    in_data  = IN_W'(1);
    sb.push_back('{RND ? 2 : 1, 0, cyc + 1});
    @(negedge clock);
    in_valid = 1'b0;
    check("busy in MAC", int'(busy), 1);
    write_coef(0, 0, 100);
    wait_idle();
    push(1, RND ? 2 : 1, 0);
    stream();
    wait_idle();
    write_coef(0, 0, 100);
    push(1, 50, 0);
    stream();
    wait_idle();

    // Same-cycle coefficient write and sample accept: tap 0 sees the new value
    coef_we   = 1'b1;
    coef_ch   = 1'b0;
    coef_idx  = 2'd0;
    coef_data = COEF_W'(10);
    in_valid  = 1'b1;
    in_data   = IN_W'(2);
    sb.push_back('{10, 0, cyc + 1});
    @(negedge clock);
    coef_we  = 1'b0;
    in_valid = 1'b0;
    wait_idle();

    // 6: reset at tap 2 aborts the computation
    in_valid = 1'b1;
    in_data  = IN_W'(5);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("busy before abort", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort out_valid", int'(out_valid), 0);
    check("abort out_data", int'(out_data), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("in_ready after reset", int'(in_ready), 1);
    check("busy after reset", int'(busy), 0);
    check("out_data after reset", int'(out_data), 0);
    write_row(0, 2, 4, 6, 8);
    write_row(1, 2, 2, 2, 2);
    push(1, 1, 1); push(0, 2, 1); push(0, 3, 1); push(0, 4, 1);
    stream();
    wait_idle();
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
